dm_access_ctrl: RTL and testbench

Data-memory access controller between the MEM stage of the pipelined CPU and the 4 KB word-organised data memory `dm_4k`. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's word address, write data and write enable. It supports byte, halfword and word accesses, with byte/halfword stores done as read-modify-write. It returns one response per request with load data, sign- or zero-extended, and a misalignment error flag.

---
 rtl/dm_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - MEM-stage load/store controller in front of the word-organised dm_4k
//
// Purpose: accepts one load/store at a time over req_valid/req_ready, drives the
// memory word address / write data / write enable, performs byte and halfword
// stores as read-modify-write, and returns one resp_valid strobe per request with
// extended load data and a misalignment/illegal-size error flag.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_we, req_size, req_sign store flag, 00 byte / 01 half / 10 word, sign-extend loads
//   req_addr, req_wdata        byte address (bits above ADDR_HI ignored), right-justified store data
//   resp_valid                 single-cycle response strobe
//   resp_rdata, resp_err       load result (0 for stores/errors), error flag
//   dm_addr, dm_din, dm_we     memory word address, write data, write enable
//   dm_dout                    memory read data (combinational from dm_addr)

module dm_access_ctrl #(
    parameter int ADDR_LO = 2,
    parameter int ADDR_HI = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [1:0]                 req_size,
    input  logic                       req_sign,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       resp_valid,
    output logic [31:0]                resp_rdata,
    output logic                       resp_err,
    output logic [ADDR_HI-ADDR_LO:0]   dm_addr,
    output logic [31:0]                dm_din,
    output logic                       dm_we,
    input  logic [31:0]                dm_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_MRG,
        S_WR,
        S_RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_HI:0] addr_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             req_err;
    logic [4:0]       lane_shift;
    logic [31:0]      lane_data;
    logic [31:0]      load_ext;
    logic [31:0]      merged;

    assign req_err = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    assign lane_shift = {addr_q[1:0], 3'b000};
    assign lane_data  = dm_dout >> lane_shift;

    always_comb begin
        load_ext = dm_dout;
        case (size_q)
            2'b00:   load_ext = {{24{sign_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_ext = {{16{sign_q & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = dm_dout;
        endcase
    end

    always_comb begin
        merged = dm_dout;
        case (size_q)
            2'b00:   merged[lane_shift +: 8] = wdata_q[7:0];
            2'b01:   merged[lane_shift +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        dm_we      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // state is already IDLE while reset is held; gate ready so nothing is offered then
                req_ready = rst_n;
                if (req_valid) begin
                    if (req_err) begin
                        state_nxt = S_RESP;
                    end else if (!req_we) begin
                        state_nxt = S_LD;
                    end else if (req_size == 2'b10) begin
                        state_nxt = S_WR;
                    end else begin
                        state_nxt = S_MRG;
                    end
                end
            end
            S_LD:   state_nxt = S_RESP;
            S_MRG:  state_nxt = S_WR;
            S_WR: begin
                dm_we     = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // wdata_q doubles as the merge buffer: MRG overwrites it so WR always drives one register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr[ADDR_HI:0];
                        size_q  <= req_size;
                        sign_q  <= req_sign;
                        wdata_q <= req_wdata;
                        rdata_q <= 32'h0;
                        err_q   <= req_err;
                    end
                end
                S_LD:    rdata_q <= load_ext;
                S_MRG:   wdata_q <= merged;
                default: ;
            endcase
        end
    end

    assign dm_addr    = addr_q[ADDR_HI:ADDR_LO];
    assign dm_din     = (state == S_WR) ? wdata_q : 32'h0;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - self-checking bench for dm_access_ctrl with byte-level reference memory

module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_LO(2), .ADDR_HI(11)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_we      (dm_we),
        .dm_dout    (dm_dout)
    );

    function automatic logic [31:0] pat(input int i);
        return (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // dm_4k stand-in: combinational read, clocked write, pattern-loaded on the first edge
    logic [31:0] mem [0:1023];
    logic        mem_init_done = 1'b0;
    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
            mem_init_done <= 1'b1;
        end else if (dm_we) begin
            mem[dm_addr] <= dm_din;
        end
    end

    // reference memory as a flat 4 KB byte array
    logic [7:0] refb [0:4095];

    task automatic ref_op(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int a;
        int nb;
        logic [31:0] v;
        a  = int'(addr % 4096);
        nb = 1 << size;
        err = (size == 2'd3) || (a % nb != 0);
        rdata = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(refb[a + i]) << (8 * i));
            if (sign && nb < 4 && v[8 * nb - 1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
            rdata = v;
        end else begin
            lat = (nb == 4) ? 2 : 3;
            for (int i = 0; i < nb; i++) refb[a + i] = wdata[8 * i +: 8];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int we_cnt, output logic [9:0] we_addr);
        int n;
        logic got;
        @(negedge clk);
        req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; got = 1'b0; we_cnt = 0; we_addr = '0; rdata = 32'hx; err = 1'bx;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (dm_we) begin
                we_cnt++;
                we_addr = dm_addr;
            end
            if (resp_valid) begin
                got = 1'b1;
                rdata = resp_rdata;
                err = resp_err;
            end
        end
        if (!got) chk("resp_timeout", 32'(lat), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vt [20];

    task automatic run_req_vs_ref(input string tag, input logic we, input logic [1:0] size,
                                  input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] e_rd, a_rd;
        logic e_err, a_err;
        int e_lat, a_lat, wc;
        logic [9:0] wa;
        ref_op(we, size, sign, addr, wdata, e_rd, e_err, e_lat);
        do_req(we, size, sign, addr, wdata, a_rd, a_err, a_lat, wc, wa);
        chk({tag, "_rdata"}, a_rd, e_rd);
        chk({tag, "_err"}, 32'(a_err), 32'(e_err));
        chk({tag, "_lat"}, 32'(a_lat), 32'(e_lat));
        chk({tag, "_we_cnt"}, 32'(wc), (we && !e_err) ? 32'd1 : 32'd0);
    endtask

    task automatic reset_abort(input int abort_cycle);
        logic [31:0] d_rd;
        logic d_err;
        int d_lat;
        int resp_seen;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_sign = 1'b0;
        req_addr = 32'h042; req_wdata = 32'h00005555; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        resp_seen = 0;
        for (int c = 1; c <= abort_cycle; c++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        if (abort_cycle == 2) chk("abort_in_wr_we_before", 32'(dm_we), 32'd1);
        rst_n = 1'b0;
        #1 chk("abort_we_drop", 32'(dm_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort_ready_after_release", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        chk("abort_no_resp", 32'(resp_seen), 32'd0);
        ref_op(1'b0, 2'b10, 1'b0, 32'h040, 32'h0, d_rd, d_err, d_lat);
        run_req_vs_ref("abort_mem_intact", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0);
        chk("abort_mem_word", mem[16], d_rd);
    endtask

    initial begin
        logic [31:0] a_rd, e_rd;
        logic a_err, e_err;
        int a_lat, e_lat, wc, busy, mism;
        logic [9:0] wa;
        logic first_ok;

        for (int i = 0; i < 1024; i++)
            for (int k = 0; k < 4; k++) refb[4 * i + k] = pat(i) >> (8 * k);

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h010,  32'h11223344, 32'h00000000, 1'b0, 2};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h010,  32'h0,        32'h11223344, 1'b0, 2};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h013,  32'h000000AB, 32'h00000000, 1'b0, 3};
        vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h010,  32'h0,        32'hAB223344, 1'b0, 2};
        vt[4]  = '{1'b1, 2'd2, 1'b0, 32'h020,  32'h80017F80, 32'h00000000, 1'b0, 2};
        vt[5]  = '{1'b0, 2'd1, 1'b1, 32'h022,  32'h0,        32'hFFFF8001, 1'b0, 2};
        vt[6]  = '{1'b0, 2'd1, 1'b0, 32'h022,  32'h0,        32'h00008001, 1'b0, 2};
        vt[7]  = '{1'b0, 2'd0, 1'b1, 32'h020,  32'h0,        32'hFFFFFF80, 1'b0, 2};
        vt[8]  = '{1'b0, 2'd0, 1'b1, 32'h021,  32'h0,        32'h0000007F, 1'b0, 2};
        vt[9]  = '{1'b1, 2'd2, 1'b0, 32'h004,  32'hDEADBEEF, 32'h00000000, 1'b0, 2};
        vt[10] = '{1'b1, 2'd1, 1'b0, 32'h005,  32'h0000CAFE, 32'h00000000, 1'b1, 1};
        vt[11] = '{1'b0, 2'd2, 1'b0, 32'h006,  32'h0,        32'h00000000, 1'b1, 1};
        vt[12] = '{1'b0, 2'd3, 1'b0, 32'h004,  32'h0,        32'h00000000, 1'b1, 1};
        vt[13] = '{1'b0, 2'd2, 1'b0, 32'h004,  32'h0,        32'hDEADBEEF, 1'b0, 2};
        vt[14] = '{1'b1, 2'd1, 1'b0, 32'h012,  32'h0000CAFE, 32'h00000000, 1'b0, 3};
        vt[15] = '{1'b0, 2'd2, 1'b0, 32'h1010, 32'h0,        32'hCAFE3344, 1'b0, 2};
        vt[16] = '{1'b0, 2'd1, 1'b0, 32'h010,  32'h0,        32'h00003344, 1'b0, 2};
        vt[17] = '{1'b0, 2'd0, 1'b1, 32'h012,  32'h0,        32'hFFFFFFFE, 1'b0, 2};
        vt[18] = '{1'b1, 2'd0, 1'b0, 32'h011,  32'hFFFFFF12, 32'h00000000, 1'b0, 3};
        vt[19] = '{1'b0, 2'd2, 1'b0, 32'h010,  32'h0,        32'hCAFE1244, 1'b0, 2};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_sign = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_dm_addr", 32'(dm_addr), 32'd0);
        chk("rst_dm_din", dm_din, 32'h0);
        rst_n = 1'b1;
        #1 chk("rst_release_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 20; i++) begin
            ref_op(vt[i].we, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata, e_rd, e_err, e_lat);
            do_req(vt[i].we, vt[i].size, vt[i].sign, vt[i].addr, vt[i].wdata,
                   a_rd, a_err, a_lat, wc, wa);
            chk($sformatf("vec%0d_rdata", i), a_rd, vt[i].rdata);
            chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vt[i].err));
            chk($sformatf("vec%0d_lat", i), 32'(a_lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_we_cnt", i), 32'(wc), (vt[i].we && !vt[i].err) ? 32'd1 : 32'd0);
            if (vt[i].we && !vt[i].err)
                chk($sformatf("vec%0d_we_addr", i), 32'(wa), 32'(vt[i].addr[11:2]));
        end
        chk("err_target_word_intact", mem[1], 32'hDEADBEEF);

        // back-to-back: word store then load held on req_valid without a gap
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
        req_addr = 32'h030; req_wdata = 32'h12345678; req_valid = 1'b1;
        ref_op(1'b1, 2'b10, 1'b0, 32'h030, 32'h12345678, e_rd, e_err, e_lat);
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'h0;
        busy = 0; first_ok = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (!req_ready) busy++;
            if (resp_valid && c == 2 && resp_rdata == 32'h0 && !resp_err) first_ok = 1'b1;
        end
        chk("b2b_busy_cycles", 32'(busy), 32'd2);
        chk("b2b_ready_in_idle", 32'(req_ready), 32'd1);
        chk("b2b_first_resp", 32'(first_ok), 32'd1);
        ref_op(1'b0, 2'b10, 1'b0, 32'h030, 32'h0, e_rd, e_err, e_lat);
        @(posedge clk);
        #1 req_valid = 1'b0;
        a_lat = 0; a_rd = 32'hx;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            if (c == 1) chk("b2b_ready_low_ld", 32'(req_ready), 32'd0);
            if (resp_valid) begin
                a_lat = c;
                a_rd = resp_rdata;
            end
        end
        chk("b2b_second_lat", 32'(a_lat), 32'd2);
        chk("b2b_second_rdata", a_rd, e_rd);

        reset_abort(1);
        reset_abort(2);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] ra;
            ra = 32'($urandom_range(0, 4095)) | ($urandom & 32'hFFFFF000);
            run_req_vs_ref($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, $urandom);
        end

        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== {refb[4 * i + 3], refb[4 * i + 2], refb[4 * i + 1], refb[4 * i]}) mism++;
        chk("final_mem_mismatch_words", 32'(mism), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
